serial_adder: RTL and testbench

- Bit-serial, parametrised successor of the team's single-bit half-adder cell.
- Adds or subtracts two WIDTH-bit operands, one bit per clock, LSB first.
- The carry is held in a flip-flop between steps.
- Sits as a low-area arithmetic unit behind a start/done handshake, for datapaths where latency is cheaper than a WIDTH-bit ripple adder.

---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, carry held in a flop between steps.
// Latency WIDTH+1 edges from start to done; start is accepted only in IDLE, otherwise dropped.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] op_A,
  input  logic [WIDTH-1:0] op_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ cy_q;
    fa_c = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_A;
          b_d     = sub ? ~op_B : op_B;
          cy_d    = sub ? 1'b1 : carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result fills from the MSB side so the LSB lands at bit 0 after WIDTH steps.
        res_d = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          carry_d = fa_c;
          ovf_d   = cy_q ^ fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
`timescale 1ns/100ps
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start, sub, carry_in;
  logic [7:0] op_A, op_B;
  logic       busy, done, carry, overflow;
  logic [7:0] sum;

  logic       start1, sub1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, carry1, ovf1;

  int tests  = 0;
  int failed = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .carry_in(carry_in),
    .op_A(op_A), .op_B(op_B), .busy(busy), .done(done), .sum(sum),
    .carry(carry), .overflow(overflow)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .carry_in(cin1),
    .op_A(a1), .op_B(b1), .busy(busy1), .done(done1), .sum(sum1),
    .carry(carry1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launches one operation, disturbs start/operands while it runs, and checks the result.
  task automatic do_op(input string tag, input logic s, input logic ci,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec, input logic eo);
    int  nbusy;
    bit  got;
    @(negedge clk);
    start = 1'b1; sub = s; carry_in = ci; op_A = a; op_B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op_A = ~a; op_B = a ^ b; sub = ~s; carry_in = ~ci;
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nbusy++;
        if (i == 2) start = 1'b1;
        if (i == 3) start = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_one"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b0; sub = 1'b0; carry_in = 1'b0; op_A = 8'h00; op_B = 8'h00;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_w1_sum", 32'(sum1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("add_ff_01", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    do_op("add_7f_01", 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    do_op("add_12_34_ci", 1'b0, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0);
    do_op("sub_05_07", 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    do_op("sub_80_01", 1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Abort mid-RUN with a reset pulse.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; carry_in = 1'b0; op_A = 8'h0A; op_B = 8'h05;
    @(posedge clk);
    #1;
    start = 1'b1; op_A = 8'h33; op_B = 8'h44;
    repeat (3) @(posedge clk);
    #3;
    start = 1'b0;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #0.5;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    #0.5;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    do_op("add_0a_05", 1'b0, 1'b0, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0);

    // WIDTH=1: 1 + 1
    @(negedge clk);
    start1 = 1'b1; sub1 = 1'b0; cin1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_done_early", 32'(done1), 32'd0);
    @(posedge clk);
    #1;
    check("w1_done", 32'(done1), 32'd1);
    check("w1_busy_off", 32'(busy1), 32'd0);
    check("w1_sum", 32'(sum1), 32'd0);
    check("w1_carry", 32'(carry1), 32'd1);
    check("w1_ovf", 32'(ovf1), 32'd1);
    @(posedge clk);
    #1;
    check("w1_done_pulse_one", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
